issue_scheduler: RTL

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/mips_pkg.sv | 78 +++++++
 rtl/issue_scheduler_if.sv | 35 +++
 rtl/issue_queue.sv | 59 +++++
 rtl/issue_scheduler.sv | 89 ++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants, queue depth default and a per-instruction
// register-usage decoder used by the dual-issue scheduler.
package mips_pkg;

    localparam int QDEPTH_DEF = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic       has_dest;
        logic [4:0] dest;
        logic       rs_vld;
        logic [4:0] rs;
        logic       rt_vld;
        logic [4:0] rt;
        logic       is_lw;
        logic       is_mem;
        logic       is_br;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d    = '0;
        d.rs = w[25:21];
        d.rt = w[20:16];
        case (w[31:26])
            OP_RTYPE: begin
                d.dest   = w[15:11];
                d.rs_vld = 1'b1;
                d.rt_vld = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                d.dest   = w[20:16];
                d.rs_vld = 1'b1;
            end
            OP_LW: begin
                d.dest   = w[20:16];
                d.rs_vld = 1'b1;
                d.is_lw  = 1'b1;
                d.is_mem = 1'b1;
            end
            OP_LUI: d.dest = w[20:16];
            OP_SW: begin
                d.rs_vld = 1'b1;
                d.rt_vld = 1'b1;
                d.is_mem = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                d.rs_vld = 1'b1;
                d.rt_vld = 1'b1;
                d.is_br  = 1'b1;
            end
            OP_J:    d.is_br = 1'b1;
            default: ;
        endcase
        // Writing $0 has no architectural effect, so it never creates a hazard.
        d.has_dest = (d.dest != 5'd0);
        return d;
    endfunction

    function automatic logic reads(input dec_t d, input logic [4:0] r);
        return (d.rs_vld && (d.rs == r)) || (d.rt_vld && (d.rt == r));
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Fetch-side push, issue-side outputs and debug visibility for issue_scheduler.
// valid/ready: a push is taken on a rising edge where in_vld0 && in_ready && !flush.
interface issue_scheduler_if
    import mips_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEF
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic          in_vld0;
    logic          in_vld1;
    logic [31:0]   in_instr0;
    logic [31:0]   in_instr1;
    logic          in_ready;
    logic          stall;
    logic          flush;
    logic          iss_vld0;
    logic          iss_vld1;
    logic [31:0]   iss_instr0;
    logic [31:0]   iss_instr1;
    logic [CW-1:0] dbg_count;
    logic          dbg_pending;

    modport master (
        output in_vld0, in_vld1, in_instr0, in_instr1, stall, flush,
        input  in_ready, iss_vld0, iss_vld1, iss_instr0, iss_instr1,
        input  dbg_count, dbg_pending
    );

    modport slave (
        input  in_vld0, in_vld1, in_instr0, in_instr1, stall, flush,
        output in_ready, iss_vld0, iss_vld1, iss_instr0, iss_instr1,
        output dbg_count, dbg_pending
    );
endinterface

// File: rtl/issue_queue.sv
// Circular instruction FIFO: up to two pushes and two pops per cycle,
// exposes the two oldest entries and the occupancy count.
module issue_queue
    import mips_pkg::*;
#(
    parameter  int QDEPTH = QDEPTH_DEF,
    localparam int AW     = $clog2(QDEPTH),
    localparam int CW     = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push0_i,
    input  logic          push1_i,
    input  logic [31:0]   wdata0_i,
    input  logic [31:0]   wdata1_i,
    input  logic [1:0]    pop_n_i,
    output logic [31:0]   rdata0_o,
    output logic [31:0]   rdata1_o,
    output logic [CW-1:0] count_o
);
    logic [31:0]   mem_q [QDEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    assign rdata0_o = mem_q[head_q];
    assign rdata1_o = mem_q[head_q + AW'(1)];
    assign count_o  = count_q;

    always_comb begin
        head_d  = head_q + AW'(pop_n_i);
        tail_d  = tail_q + AW'(push0_i) + AW'(push1_i);
        count_d = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_n_i);
        if (flush_i) begin
            head_d  = tail_q;
            tail_d  = tail_q;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push0_i) mem_q[tail_q] <= wdata0_i;
        if (push1_i) mem_q[tail_q + AW'(1)] <= wdata1_i;
    end
endmodule

// File: rtl/issue_scheduler.sv
// In-order dual-issue scheduler: decodes the two oldest queued instructions,
// applies pairing rules and a single-entry load-use scoreboard.
module issue_scheduler
    import mips_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEF
) (
    input logic              clk,
    input logic              rst_n,
    issue_scheduler_if.slave bus
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [CW-1:0] count;
    logic [31:0]   word0, word1;
    dec_t          d0, d1;
    logic          in_ready, push0, push1;
    logic          iss0, iss1, pair_ok;
    logic          pend_q, pend_d;
    logic [4:0]    pend_reg_q, pend_reg_d;

    assign in_ready = (count <= CW'(QDEPTH - 2));
    assign push0    = bus.in_vld0 && in_ready && !bus.flush;
    assign push1    = push0 && bus.in_vld1;

    issue_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (bus.flush),
        .push0_i  (push0),
        .push1_i  (push1),
        .wdata0_i (bus.in_instr0),
        .wdata1_i (bus.in_instr1),
        .pop_n_i  ({1'b0, iss0} + {1'b0, iss1}),
        .rdata0_o (word0),
        .rdata1_o (word1),
        .count_o  (count)
    );

    assign d0 = decode(word0);
    assign d1 = decode(word1);

    assign iss0 = (count != '0) && !bus.stall && !bus.flush
                  && !(pend_q && reads(d0, pend_reg_q));

    assign pair_ok = (count >= CW'(2))
                     && !(d0.has_dest && reads(d1, d0.dest))
                     && !(d0.has_dest && d1.has_dest && (d0.dest == d1.dest))
                     && !(d0.is_mem && d1.is_mem)
                     && !d0.is_br && !d1.is_br
                     && !(pend_q && reads(d1, pend_reg_q));

    assign iss1 = iss0 && pair_ok;

    // A newly issued load re-arms the scoreboard; otherwise one unstalled edge clears it.
    always_comb begin
        pend_d     = pend_q;
        pend_reg_d = pend_reg_q;
        if (bus.flush) begin
            pend_d = 1'b0;
        end else if (iss1 && d1.is_lw && d1.has_dest) begin
            pend_d     = 1'b1;
            pend_reg_d = d1.dest;
        end else if (iss0 && d0.is_lw && d0.has_dest) begin
            pend_d     = 1'b1;
            pend_reg_d = d0.dest;
        end else if (!bus.stall) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= 1'b0;
            pend_reg_q <= 5'd0;
        end else begin
            pend_q     <= pend_d;
            pend_reg_q <= pend_reg_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.iss_vld0    = iss0;
    assign bus.iss_vld1    = iss1;
    assign bus.iss_instr0  = iss0 ? word0 : 32'h0;
    assign bus.iss_instr1  = iss1 ? word1 : 32'h0;
    assign bus.dbg_count   = count;
    assign bus.dbg_pending = pend_q;
endmodule
